// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer.
package demux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
endpackage

// File: rtl/demux_out_slot.sv
// One output channel: a single-entry holding slot with valid bit and a
// wrap-around count of completed output handshakes.
module demux_out_slot #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt
);
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             w_drain;

  assign w_drain = r_valid && out_ready;

  // A load in the same cycle as a drain keeps the slot full with the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      if (load) begin
        r_valid <= 1'b1;
        r_data  <= load_data;
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end
      if (w_drain) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign valid = r_valid;
  assign data  = r_data;
  assign cnt   = r_cnt;
endmodule

// File: rtl/demux_1x4_stream.sv
// Registered 1-to-4 stream demultiplexer: select decode, in_ready mux and
// four independent output slots.
module demux_1x4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*WIDTH-1:0]    out_data,
  output logic [NUM_CH-1:0]     out_valid,
  input  logic [NUM_CH-1:0]     out_ready,
  output logic [4*CNT_W-1:0]    out_cnt
);
  logic [NUM_CH-1:0] w_valid;
  logic [NUM_CH-1:0] w_load;
  logic              w_accept;

  // Only the addressed channel can stall the input (head-of-line blocking).
  assign in_ready = !w_valid[in_sel] || out_ready[in_sel];
  assign w_accept = in_valid && in_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    assign w_load[g] = w_accept && (in_sel == SEL_W'(g));

    demux_out_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (w_load[g]),
      .load_data (in_data),
      .out_ready (out_ready[g]),
      .valid     (w_valid[g]),
      .data      (out_data[g*WIDTH +: WIDTH]),
      .cnt       (out_cnt[g*CNT_W +: CNT_W])
    );
  end

  assign out_valid = w_valid;
endmodule
